// File: rtl/bram_regfile_pkg.sv
// Shared offsets, version constant and channel-address decode for the bram_regfile_mc bank.
package bram_regfile_pkg;

  localparam logic [31:0] OFF_ID       = 32'h00;
  localparam logic [31:0] OFF_PARAM    = 32'h04;
  localparam logic [31:0] OFF_IRQ_PEND = 32'h08;
  localparam logic [31:0] OFF_IRQ_MASK = 32'h0C;
  localparam logic [31:0] CH_BASE      = 32'h10;
  localparam logic [31:0] CH_STRIDE    = 32'h10;

  localparam logic [3:0] SUB_CONTROL = 4'h0;
  localparam logic [3:0] SUB_SELECT  = 4'h4;
  localparam logic [3:0] SUB_STATUS  = 4'h8;
  localparam logic [3:0] SUB_STICKY  = 4'hC;

  localparam logic [7:0] VERSION = 8'h02;

  typedef struct packed {
    logic       hit;
    logic [3:0] ch;
    logic [3:0] sub;
  } ch_dec_t;

  // hit is only set for offsets inside the channel window and below n_ch
  function automatic ch_dec_t ch_decode(input logic [31:0] off, input int unsigned n_ch);
    logic [31:0] rel;
    logic [31:0] idx;
    ch_dec_t     d;
    rel   = off - CH_BASE;
    idx   = rel / CH_STRIDE;
    d.hit = (off >= CH_BASE) && (idx < n_ch);
    d.ch  = idx[3:0];
    d.sub = 4'(rel % CH_STRIDE);
    return d;
  endfunction

endpackage

// File: rtl/bram_regfile_ch.sv
// One channel register set: CONTROL, SELECT, registered STATUS, W1C STICKY and the CONTROL write strobe.
// STICKY exists only when BRAM_REGFILE_STICKY_EN is defined; otherwise it reads as 0.
module bram_regfile_ch (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_ctrl,
  input  logic        wr_sel,
  input  logic [31:0] wdata,
  input  logic [31:0] clr_mask,
  input  logic [31:0] status_in,
  output logic [31:0] control,
  output logic [31:0] select,
  output logic [31:0] status,
  output logic [31:0] sticky,
  output logic        ctrl_wr_stb
);
  import bram_regfile_pkg::*;

  logic [31:0] control_reg;
  logic [31:0] select_reg;
  logic [31:0] status_reg;
  logic        stb_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      control_reg <= '0;
      select_reg  <= '0;
      status_reg  <= '0;
      stb_reg     <= 1'b0;
    end else begin
      if (wr_ctrl) control_reg <= wdata;
      if (wr_sel)  select_reg  <= wdata;
      status_reg <= status_in;
      stb_reg    <= wr_ctrl;
    end
  end

`ifdef BRAM_REGFILE_STICKY_EN
  logic [31:0] sticky_reg;

  // OR-ing STATUS after the clear makes a simultaneous set win
  always_ff @(posedge clk) begin
    if (reset) sticky_reg <= '0;
    else       sticky_reg <= (sticky_reg & ~clr_mask) | status_reg;
  end

  assign sticky = sticky_reg;
`else
  logic unused_clr;
  assign unused_clr = ^clr_mask;
  assign sticky     = '0;
`endif

  assign control     = control_reg;
  assign select      = select_reg;
  assign status      = status_reg;
  assign ctrl_wr_stb = stb_reg;

endmodule

// File: rtl/bram_regfile_mc.sv
// Multi-channel register bank: address decode, global registers, registered read path and irq.
// Optional feature macro: BRAM_REGFILE_STICKY_EN (STICKY / IRQ_PEND / IRQ_MASK / irq).
module bram_regfile_mc #(
  parameter int          BASE_ADDR  = 0,
  parameter int          ADDR_WIDTH = 12,
  parameter int          N_CH       = 4,
  parameter logic [31:0] ID_VALUE   = 32'hABCD2000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] reg_addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata,
  output logic                  rd_valid,
  input  logic [32*N_CH-1:0]    status_in,
  output logic [32*N_CH-1:0]    control_o,
  output logic [32*N_CH-1:0]    select_o,
  output logic [N_CH-1:0]       ctrl_wr_stb,
  output logic                  irq
);
  import bram_regfile_pkg::*;

  logic [ADDR_WIDTH-1:0] off_a;
  logic [31:0]           off;
  logic                  unused_addr;
  ch_dec_t               dec;
  logic                  glob_hit;

  assign off_a       = reg_addr - ADDR_WIDTH'(BASE_ADDR);
  assign off         = 32'({off_a[ADDR_WIDTH-1:2], 2'b00});
  assign unused_addr = ^off_a[1:0];
  assign dec         = ch_decode(off, N_CH);
  assign glob_hit    = off < CH_BASE;

  logic [31:0]     control_a [N_CH];
  logic [31:0]     select_a  [N_CH];
  logic [31:0]     status_a  [N_CH];
  logic [31:0]     sticky_a  [N_CH];
  logic [N_CH-1:0] wr_ctrl;
  logic [N_CH-1:0] wr_sel;
  logic [N_CH-1:0] wr_stky;
  logic [N_CH-1:0] irq_pend;

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      logic ch_wr;
      assign ch_wr        = wr_en && dec.hit && (dec.ch == 4'(gi));
      assign wr_ctrl[gi]  = ch_wr && (dec.sub == SUB_CONTROL);
      assign wr_sel[gi]   = ch_wr && (dec.sub == SUB_SELECT);
      assign wr_stky[gi]  = ch_wr && (dec.sub == SUB_STICKY);
      assign irq_pend[gi] = |sticky_a[gi];

      bram_regfile_ch u_ch (
        .clk         (clk),
        .reset       (reset),
        .wr_ctrl     (wr_ctrl[gi]),
        .wr_sel      (wr_sel[gi]),
        .wdata       (wdata),
        .clr_mask    (wr_stky[gi] ? wdata : 32'h0),
        .status_in   (status_in[32*gi +: 32]),
        .control     (control_a[gi]),
        .select      (select_a[gi]),
        .status      (status_a[gi]),
        .sticky      (sticky_a[gi]),
        .ctrl_wr_stb (ctrl_wr_stb[gi])
      );

      assign control_o[32*gi +: 32] = control_a[gi];
      assign select_o[32*gi +: 32]  = select_a[gi];
    end
  endgenerate

  logic [N_CH-1:0] mask_reg;
  logic            irq_reg;

`ifdef BRAM_REGFILE_STICKY_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      mask_reg <= '0;
      irq_reg  <= 1'b0;
    end else begin
      if (wr_en && glob_hit && (off[3:0] == OFF_IRQ_MASK[3:0]))
        mask_reg <= wdata[N_CH-1:0];
      irq_reg <= |(irq_pend & mask_reg);
    end
  end
`else
  assign mask_reg = '0;
  assign irq_reg  = 1'b0;
`endif

  logic [31:0] rd_mux;

  always_comb begin
    rd_mux = '0;
    if (glob_hit) begin
      case (off[3:0])
        OFF_ID[3:0]:       rd_mux = ID_VALUE;
        OFF_PARAM[3:0]:    rd_mux = {VERSION, 8'(N_CH), 16'h0};
        OFF_IRQ_PEND[3:0]: rd_mux = 32'(irq_pend);
        OFF_IRQ_MASK[3:0]: rd_mux = 32'(mask_reg);
        default:           rd_mux = '0;
      endcase
    end else if (dec.hit) begin
      for (int c = 0; c < N_CH; c++) begin
        if (dec.ch == 4'(c)) begin
          case (dec.sub)
            SUB_CONTROL: rd_mux = control_a[c];
            SUB_SELECT:  rd_mux = select_a[c];
            SUB_STATUS:  rd_mux = status_a[c];
            SUB_STICKY:  rd_mux = sticky_a[c];
            default:     rd_mux = '0;
          endcase
        end
      end
    end
  end

  logic [31:0] rdata_reg;
  logic        rd_valid_reg;

  // the mux sees pre-edge register values, so a same-cycle write is not visible to the read
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_reg    <= '0;
      rd_valid_reg <= 1'b0;
    end else begin
      rd_valid_reg <= rd_en;
      if (rd_en) rdata_reg <= rd_mux;
    end
  end

  assign rdata    = rdata_reg;
  assign rd_valid = rd_valid_reg;
  assign irq      = irq_reg;

endmodule

// File: tb/tb_bram_regfile_mc.sv
// Directed self-checking bench for bram_regfile_mc (N_CH = 4); expectations follow BRAM_REGFILE_STICKY_EN.
module tb_bram_regfile_mc;

`ifdef BRAM_REGFILE_STICKY_EN
  localparam bit STK = 1'b1;
`else
  localparam bit STK = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         wr_en;
  logic         rd_en;
  logic [11:0]  reg_addr;
  logic [31:0]  wdata;
  logic [31:0]  rdata;
  logic         rd_valid;
  logic [127:0] status_in;
  logic [127:0] control_o;
  logic [127:0] select_o;
  logic [3:0]   ctrl_wr_stb;
  logic         irq;

  int checks = 0;
  int errors = 0;

  bram_regfile_mc #(
    .BASE_ADDR  (0),
    .ADDR_WIDTH (12),
    .N_CH       (4),
    .ID_VALUE   (32'hABCD2000)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .wr_en       (wr_en),
    .rd_en       (rd_en),
    .reg_addr    (reg_addr),
    .wdata       (wdata),
    .rdata       (rdata),
    .rd_valid    (rd_valid),
    .status_in   (status_in),
    .control_o   (control_o),
    .select_o    (select_o),
    .ctrl_wr_stb (ctrl_wr_stb),
    .irq         (irq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic w, input logic r, input logic [11:0] a, input logic [31:0] d);
    wr_en    = w;
    rd_en    = r;
    reg_addr = a;
    wdata    = d;
  endtask

  initial begin
    // reset held two cycles while a write and a read are requested
    reset     = 1'b1;
    status_in = '0;
    drive(1'b1, 1'b1, 12'h030, 32'hFFFF_FFFF);
    tick();
    tick();
    check("rst_control", control_o, 128'h0);
    check("rst_select", select_o, 128'h0);
    check("rst_stb", 128'(ctrl_wr_stb), 128'h0);
    check("rst_rdata", 128'(rdata), 128'h0);
    check("rst_rd_valid", 128'(rd_valid), 128'h0);
    check("rst_irq", 128'(irq), 128'h0);

    reset = 1'b0;
    drive(1'b0, 1'b1, 12'h000, 32'h0);
    tick();
    check("id_valid", 128'(rd_valid), 128'h1);
    check("id_rdata", 128'(rdata), 128'hABCD2000);
    drive(1'b0, 1'b1, 12'h004, 32'h0);
    tick();
    check("param_rdata", 128'(rdata), 128'h02040000);
    drive(1'b0, 1'b0, 12'h000, 32'h0);
    tick();
    check("valid_pulse", 128'(rd_valid), 128'h0);
    check("rdata_hold", 128'(rdata), 128'h02040000);

    // CONTROL write to channel 2
    drive(1'b1, 1'b0, 12'h030, 32'h0000_00A5);
    tick();
    drive(1'b0, 1'b0, 12'h000, 32'h0);
    check("ctrl2_value", control_o, {32'h0, 32'hA5, 64'h0});
    check("ctrl2_stb", 128'(ctrl_wr_stb), 128'b0100);
    tick();
    check("ctrl2_stb_end", 128'(ctrl_wr_stb), 128'h0);

    // back-to-back CONTROL writes on channel 0 give consecutive pulses
    drive(1'b1, 1'b0, 12'h010, 32'h1);
    tick();
    check("b2b_stb1", 128'(ctrl_wr_stb), 128'b0001);
    drive(1'b1, 1'b0, 12'h010, 32'h2);
    tick();
    drive(1'b0, 1'b0, 12'h000, 32'h0);
    check("b2b_stb2", 128'(ctrl_wr_stb), 128'b0001);
    check("b2b_value", control_o, {32'h0, 32'hA5, 32'h0, 32'h2});
    tick();
    check("b2b_stb_end", 128'(ctrl_wr_stb), 128'h0);

    // same-cycle write and read of SELECT channel 0
    drive(1'b1, 1'b0, 12'h014, 32'h1111);
    tick();
    drive(1'b1, 1'b1, 12'h014, 32'h2222);
    tick();
    check("rw_old", 128'(rdata), 128'h1111);
    drive(1'b0, 1'b1, 12'h014, 32'h0);
    tick();
    check("rw_new", 128'(rdata), 128'h2222);
    check("sel0_out", select_o, 128'h2222);
    drive(1'b0, 1'b1, 12'h030, 32'h0);
    tick();
    check("ctrl2_read", 128'(rdata), 128'hA5);

    // channel 4 does not exist with N_CH = 4
    drive(1'b0, 1'b1, 12'h050, 32'h0);
    tick();
    check("ch4_read", 128'(rdata), 128'h0);
    drive(1'b1, 1'b0, 12'h050, 32'hFFFF_FFFF);
    tick();
    drive(1'b1, 1'b0, 12'h054, 32'hFFFF_FFFF);
    tick();
    drive(1'b0, 1'b0, 12'h000, 32'h0);
    check("ch4_ctrl", control_o, {32'h0, 32'hA5, 32'h0, 32'h2});
    check("ch4_sel", select_o, 128'h2222);
    check("ch4_stb", 128'(ctrl_wr_stb), 128'h0);

    // IRQ_MASK: only the low N_CH bits are kept
    drive(1'b1, 1'b0, 12'h00C, 32'hFFFF_FFFF);
    tick();
    drive(1'b0, 1'b1, 12'h00C, 32'h0);
    tick();
    check("mask_read", 128'(rdata), STK ? 128'hF : 128'h0);
    drive(1'b1, 1'b0, 12'h00C, 32'h2);
    tick();

    // one-cycle pulse on channel 1 bit 3
    drive(1'b0, 1'b0, 12'h000, 32'h0);
    status_in = 128'h8 << 32;
    tick();
    status_in = '0;
    check("irq_lag1", 128'(irq), 128'h0);
    drive(1'b0, 1'b1, 12'h028, 32'h0);
    tick();
    check("status1_read", 128'(rdata), 128'h8);
    check("irq_lag2", 128'(irq), 128'h0);
    drive(1'b0, 1'b1, 12'h02C, 32'h0);
    tick();
    check("sticky1_read", 128'(rdata), STK ? 128'h8 : 128'h0);
    check("irq_rise", 128'(irq), STK ? 128'h1 : 128'h0);
    drive(1'b0, 1'b1, 12'h008, 32'h0);
    tick();
    check("pend_read", 128'(rdata), STK ? 128'h2 : 128'h0);
    drive(1'b1, 1'b0, 12'h02C, 32'h8);
    tick();
    check("irq_clear_edge", 128'(irq), STK ? 128'h1 : 128'h0);
    drive(1'b0, 1'b1, 12'h02C, 32'h0);
    tick();
    check("irq_drop", 128'(irq), 128'h0);
    check("sticky1_cleared", 128'(rdata), 128'h0);

    // set wins over a simultaneous clear
    drive(1'b0, 1'b0, 12'h000, 32'h0);
    status_in = 128'h1 << 32;
    tick();
    tick();
    drive(1'b1, 1'b0, 12'h02C, 32'h1);
    tick();
    status_in = '0;
    drive(1'b0, 1'b1, 12'h02C, 32'h0);
    tick();
    check("set_wins", 128'(rdata), STK ? 128'h1 : 128'h0);
    drive(1'b0, 1'b0, 12'h000, 32'h0);
    tick();
    check("irq_set_wins", 128'(irq), STK ? 128'h1 : 128'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
